byte_queue: RTL and testbench

- 8-entry circular byte FIFO directly downstream of the deserializer.
- Accepts a completed byte when the deserializer's data_ready is high and confirms it with ack_out, which is wired to the deserializer's ack_in.
- Bytes are released in order on dequeue_in.
- Occupancy is published on len_out for the downstream consumer and the top-level display.

---
 rtl/byte_queue_pkg.sv | 20 ++
 rtl/queue_mem.sv | 39 +++
 rtl/byte_queue.sv | 162 ++++++++++++++++
 tb/tb_byte_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_queue_pkg.sv
// ----------------------------------------------------------------------------
// byte_queue_pkg
//   Shared definitions for the byte queue that sits behind the deserializer:
//   default geometry and the enqueue handshake state type.
// ----------------------------------------------------------------------------
package byte_queue_pkg;

    localparam int WIDTH = 8;  // bits per entry
    localparam int DEPTH = 8;  // number of entries, power of two
    localparam int LEN_W = 4;  // occupancy width, 2**LEN_W > DEPTH

    // ARMED : ready to take the next byte offered by the deserializer.
    // DRAIN : a byte was just taken; wait for data_ready to fall so a
    //         level-held valid cannot be written twice.
    typedef enum logic {
        ARMED = 1'b0,
        DRAIN = 1'b1
    } enq_state_t;

endpackage : byte_queue_pkg

// File: rtl/queue_mem.sv
// ----------------------------------------------------------------------------
// queue_mem
//   DEPTH x WIDTH register file: one synchronous write port, one
//   combinational read port.
//
//   Ports:
//     clock_10KHz  in   write clock
//     we           in   write enable
//     waddr        in   write address
//     wdata        in   write data
//     raddr        in   read address
//     rdata        out  read data, combinational from raddr
// ----------------------------------------------------------------------------
module queue_mem #(
    parameter int WIDTH = byte_queue_pkg::WIDTH,
    parameter int DEPTH = byte_queue_pkg::DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock_10KHz,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; an entry is only read after it was
    // written, so clearing it would just cost a reset net per bit.
    always_ff @(posedge clock_10KHz) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : queue_mem

// File: rtl/byte_queue.sv
// ----------------------------------------------------------------------------
// byte_queue
//   8-entry circular byte FIFO directly downstream of the deserializer.
//   A byte offered on enqueue_in is written once and confirmed with a
//   one-cycle ack_out pulse; the handshake FSM then waits for enqueue_in to
//   fall before it will take another byte. Bytes leave in order on
//   dequeue_in; data_out holds the last popped byte.
//
//   Ports:
//     clock_10KHz  in   block clock, all state on its rising edge
//     reset        in   asynchronous, active-low
//     data_in      in   byte from the deserializer
//     enqueue_in   in   byte valid (deserializer data_ready)
//     ack_out      out  one-cycle accept pulse (deserializer ack_in)
//     dequeue_in   in   pop request from the consumer
//     data_out     out  last popped byte
//     len_out      out  occupancy, 0..DEPTH
//     full_out     out  len_out == DEPTH
//     empty_out    out  len_out == 0
// ----------------------------------------------------------------------------
module byte_queue
    import byte_queue_pkg::*;
#(
    parameter int WIDTH = byte_queue_pkg::WIDTH,
    parameter int DEPTH = byte_queue_pkg::DEPTH,
    parameter int LEN_W = byte_queue_pkg::LEN_W
) (
    input  logic             clock_10KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    output logic             ack_out,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] len_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] FULL_N = LEN_W'(DEPTH);

    enq_state_t       state, next_state;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LEN_W-1:0] count, next_count;
    logic             wr_en, pop_en;
    logic [WIDTH-1:0] rd_data;

    // ------------------------------------------------------------------
    // Enqueue handshake FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of process order.
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            state <= ARMED;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        unique case (state)
            ARMED: begin
                // Full is judged on the registered count: when full the
                // byte waits upstream and is retried while still ARMED.
                if (enqueue_in && !full_out) begin
                    wr_en      = 1'b1;
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!enqueue_in) begin
                    next_state = ARMED;
                end
            end
            default: next_state = ARMED;
        endcase
    end

    // Pop is judged on the registered count too: a pop issued while empty
    // is dropped even if a write lands in the same cycle.
    assign pop_en = dequeue_in && !empty_out;

    // Accept pulse follows the write edge by one cycle; DRAIN guarantees
    // at least one idle cycle before the next write, so it never repeats
    // back to back.
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            ack_out <= 1'b0;
        end else begin
            ack_out <= wr_en;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and storage; DEPTH is a power of two so pointers wrap by
    // natural overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clock_10KHz (clock_10KHz),
        .we          (wr_en),
        .waddr       (wr_ptr),
        .wdata       (data_in),
        .raddr       (rd_ptr),
        .rdata       (rd_data)
    );

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (pop_en) begin
            data_out <= rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy. Flags are registered from the next count so they come
    // straight off flops and change together with len_out.
    // ------------------------------------------------------------------
    always_comb begin
        next_count = count;
        unique case ({wr_en, pop_en})
            2'b10:   next_count = count + LEN_W'(1);
            2'b01:   next_count = count - LEN_W'(1);
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            full_out  <= 1'b0;
            empty_out <= 1'b1;
        end else begin
            count     <= next_count;
            full_out  <= (next_count == FULL_N);
            empty_out <= (next_count == '0);
        end
    end

    assign len_out = count;

endmodule : byte_queue

// File: tb/tb_byte_queue.sv
// ----------------------------------------------------------------------------
// tb_byte_queue
//   Directed bench for byte_queue. Stimulus drives inputs on the falling
//   edge and pushes the expected data_out of every pop request into a
//   scoreboard queue; a separate monitor pops and compares just after the
//   rising edge on which the request was sampled. A second monitor watches
//   ack_out for back-to-back pulses.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_byte_queue;
    import byte_queue_pkg::*;

    logic       clock_10KHz = 1'b0;
    logic       reset       = 1'b0;
    logic [7:0] data_in     = '0;
    logic       enqueue_in  = 1'b0;
    logic       dequeue_in  = 1'b0;
    logic       ack_out;
    logic [7:0] data_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;

    byte_queue dut (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .data_in     (data_in),
        .enqueue_in  (enqueue_in),
        .ack_out     (ack_out),
        .dequeue_in  (dequeue_in),
        .data_out    (data_out),
        .len_out     (len_out),
        .full_out    (full_out),
        .empty_out   (empty_out)
    );

    always #5 clock_10KHz = ~clock_10KHz;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_q[$];          // bytes held by the queue
    bit         m_armed  = 1'b1; // handshake ready for a new byte
    logic [7:0] last_pop = '0;   // expected data_out
    logic [7:0] exp_pop_q[$];    // scoreboard: data_out after each pop request
    int         ack_total = 0;
    bit         prev_ack  = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus, entered and left on a falling edge.
    task automatic cycle(input bit en, input logic [7:0] din, input bit deq);
        int pre;
        bit wr;
        bit pp;
        enqueue_in = en;
        data_in    = din;
        dequeue_in = deq;
        pre = m_q.size();
        wr  = m_armed && en && (pre < DEPTH);
        pp  = deq && (pre > 0);
        if (pp)  last_pop = m_q.pop_front();
        if (deq) exp_pop_q.push_back(last_pop);
        if (wr)  m_q.push_back(din);
        if (wr) m_armed = 1'b0;
        else if (!m_armed && !en) m_armed = 1'b1;
        @(negedge clock_10KHz);
        check("ack_out",   ack_out,   32'(wr));
        check("len_out",   len_out,   32'(m_q.size()));
        check("full_out",  full_out,  32'(m_q.size() == DEPTH));
        check("empty_out", empty_out, 32'(m_q.size() == 0));
    endtask

    task automatic push_byte(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    // Pop monitor
    initial begin
        forever begin
            @(posedge clock_10KHz);
            if (reset && dequeue_in) begin
                #1;
                if (exp_pop_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL pop_scoreboard: got pop with no expectation at %0t", $time);
                end else begin
                    check("pop_data_out", data_out, 32'(exp_pop_q.pop_front()));
                end
            end
        end
    end

    // Ack monitor
    initial begin
        forever begin
            @(posedge clock_10KHz);
            #1;
            if (!reset) begin
                prev_ack = 1'b0;
            end else begin
                if (ack_out) begin
                    ack_total++;
                    if (prev_ack) check("ack_back_to_back", 32'(prev_ack), 32'd0);
                end
                prev_ack = ack_out;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;

        // Reset state
        repeat (3) @(negedge clock_10KHz);
        check("rst_len",   len_out,   0);
        check("rst_empty", empty_out, 1);
        check("rst_full",  full_out,  0);
        check("rst_ack",   ack_out,   0);
        check("rst_data",  data_out,  8'h00);
        reset = 1'b1;
        @(negedge clock_10KHz);

        // Empty pop is ignored
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("empty_pop_data", data_out, 8'h00);
        check("empty_pop_len",  len_out,  0);
        check("empty_pop_acks", ack_total, 0);

        // Level-held valid writes once
        a0 = ack_total;
        repeat (5) cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("hold_len",  len_out, 1);
        check("hold_acks", ack_total - a0, 1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("hold_pop_data", data_out, 8'hA5);
        check("hold_pop_len",  len_out,  0);

        // Fill and backpressure
        for (int b = 1; b <= 8; b++) push_byte(8'(b));
        a0 = ack_total;
        cycle(1'b1, 8'h09, 1'b0);
        cycle(1'b1, 8'h09, 1'b0);
        check("bp_full", full_out, 1);
        check("bp_len",  len_out,  8);
        check("bp_no_ack", ack_total - a0, 0);
        cycle(1'b1, 8'h09, 1'b1);           // full: pop only
        check("bp_pop_data", data_out, 8'h01);
        check("bp_pop_len",  len_out,  7);
        check("bp_pop_no_ack", ack_total - a0, 0);
        cycle(1'b1, 8'h09, 1'b0);           // retried write lands
        check("bp_retry_len", len_out, 8);
        check("bp_retry_ack", ack_total - a0, 1);
        cycle(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            check("bp_drain_data", data_out, 32'(8'h02 + k));
        end
        cycle(1'b0, 8'h00, 1'b0);
        check("bp_drain_empty", empty_out, 1);

        // Wrap-around ordering, occupancy 4..5
        for (int b = 8'h10; b <= 8'h13; b++) push_byte(8'(b));
        for (int b = 8'h14; b <= 8'h23; b++) begin
            cycle(1'b1, 8'(b), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
            check("wrap_order", data_out, 32'(b - 4));
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("wrap_last", data_out, 8'h23);
        check("wrap_empty", empty_out, 1);

        // Simultaneous enqueue and dequeue while empty: write only
        cycle(1'b1, 8'h40, 1'b1);
        check("sim_empty_hold", data_out, 8'h23);
        check("sim_empty_len",  len_out,  1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("sim_empty_pop", data_out, 8'h40);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous enqueue and dequeue at len 4
        for (int b = 8'h30; b <= 8'h33; b++) push_byte(8'(b));
        cycle(1'b1, 8'h34, 1'b1);
        check("sim4_len",  len_out,  4);
        check("sim4_data", data_out, 8'h30);
        cycle(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            check("sim4_order", data_out, 32'(8'h31 + k));
        end
        cycle(1'b0, 8'h00, 1'b0);

        // Asynchronous reset while in DRAIN with len 6
        for (int b = 8'h50; b <= 8'h54; b++) push_byte(8'(b));
        cycle(1'b1, 8'h55, 1'b0);           // now DRAIN, ack high
        check("arst_pre_len", len_out, 6);
        check("arst_pre_ack", ack_out, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ack",   ack_out,   0);
        check("arst_len",   len_out,   0);
        check("arst_empty", empty_out, 1);
        check("arst_data",  data_out,  8'h00);
        enqueue_in = 1'b0;
        m_q.delete();
        m_armed  = 1'b1;
        last_pop = 8'h00;
        repeat (2) @(negedge clock_10KHz);
        reset = 1'b1;
        a0 = ack_total;
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("arst_after_ack", ack_total - a0, 1);
        check("arst_after_len", len_out, 1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("arst_after_data", data_out, 8'h5A);

        check("scoreboard_drained", 32'(exp_pop_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_byte_queue
